instcache_control: RTL and testbench

Control FSM for the two-way, 8-set, 32-byte-line read-only L1 instruction cache datapath. It accepts fetch requests from the CPU-side port, resolves hits in one cycle, and sequences line fills from the physical-memory port on a miss. It drives the datapath's tag, valid, LRU and write-status controls and keeps saturating hit/miss counters for performance analysis. It sits between the fetch stage and the L2/arbiter memory port.

---
 rtl/instcache_control.sv | 135 +++++++++++++
 tb/tb_instcache_control.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instcache_control.sv
// instcache_control: control FSM for a 2-way, 8-set, 32-byte-line read-only
// L1 instruction cache. Hits are answered in the request cycle. On a miss it
// fetches the line from physical memory and fills the LRU way. It also keeps
// saturating hit and miss counters.
//   clk, rst              clock, synchronous active-high reset
//   mem_read / mem_resp   CPU fetch request / read data valid
//   pmem_read / pmem_resp memory line request / line valid
//   HIT, way_hit, lru_data, valid_out     datapath status
//   LD_LRU_in, lru_in_value, LD_VALID, valid_in, LD_TAG, W_CACHE_STATUS
//                         datapath controls
//   hit_count, miss_count saturating performance counters
module instcache_control #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  output logic                 mem_resp,
  input  logic                 pmem_resp,
  output logic                 pmem_read,
  input  logic                 HIT,
  input  logic                 way_hit,
  input  logic                 lru_data,
  input  logic [1:0]           valid_out,
  output logic                 LD_LRU_in,
  output logic                 lru_in_value,
  output logic [1:0]           LD_VALID,
  output logic                 valid_in,
  output logic [1:0]           LD_TAG,
  output logic [2:0]           W_CACHE_STATUS,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    FETCH     = 2'd1,
    FILL_WAIT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 after_fill_q;
  logic                 hit_ev, miss_ev;
  logic [CNT_WIDTH-1:0] hit_count_q, hit_count_d;
  logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;

  // Victim selection is purely LRU, so the per-way valid bits are not needed.
  logic unused_valid;
  assign unused_valid = ^valid_out;

  always_comb begin
    state_d        = state_q;
    mem_resp       = 1'b0;
    pmem_read      = 1'b0;
    LD_LRU_in      = 1'b0;
    lru_in_value   = 1'b0;
    LD_VALID       = '0;
    valid_in       = 1'b0;
    LD_TAG         = '0;
    W_CACHE_STATUS = 3'b000;
    hit_ev         = 1'b0;
    miss_ev        = 1'b0;

    unique case (state_q)
      CHECK: begin
        if (mem_read) begin
          if (HIT) begin
            mem_resp     = 1'b1;
            LD_LRU_in    = 1'b1;
            lru_in_value = ~way_hit;
            // The retry that completes a fill is not a first-look hit.
            hit_ev       = ~after_fill_q;
          end else begin
            state_d = FETCH;
            miss_ev = 1'b1;
          end
        end
      end
      FETCH: begin
        pmem_read      = 1'b1;
        W_CACHE_STATUS = 3'b011;
        if (pmem_resp) begin
          W_CACHE_STATUS   = 3'b111;
          LD_TAG[lru_data]   = 1'b1;
          LD_VALID[lru_data] = 1'b1;
          valid_in         = 1'b1;
          state_d          = FILL_WAIT;
        end
      end
      FILL_WAIT: state_d = CHECK;
      default:   state_d = CHECK;
    endcase

    // Reset wins over everything, including a coincident pmem_resp.
    if (rst) begin
      mem_resp       = 1'b0;
      pmem_read      = 1'b0;
      LD_LRU_in      = 1'b0;
      lru_in_value   = 1'b0;
      LD_VALID       = '0;
      valid_in       = 1'b0;
      LD_TAG         = '0;
      W_CACHE_STATUS = 3'b000;
    end
  end

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit_ev && (hit_count_q != '1)) begin
      hit_count_d = hit_count_q + CNT_WIDTH'(1);
    end
    if (miss_ev && (miss_count_q != '1)) begin
      miss_count_d = miss_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CHECK;
      after_fill_q <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      after_fill_q <= (state_q == FILL_WAIT);
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_instcache_control.sv
// Self-checking bench for instcache_control. A small behavioural datapath
// (tags, valids, delayed LRU register) answers the controller; a memory
// responder raises pmem_resp after a chosen number of FETCH cycles. Expected
// request-to-response latencies are queued at request time and popped when
// mem_resp appears.
module tb_instcache_control;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read;
  logic          mem_resp;
  logic          pmem_resp;
  logic          pmem_read;
  logic          HIT;
  logic          way_hit;
  logic          lru_data;
  logic [1:0]    valid_out;
  logic          LD_LRU_in;
  logic          lru_in_value;
  logic [1:0]    LD_VALID;
  logic          valid_in;
  logic [1:0]    LD_TAG;
  logic [2:0]    W_CACHE_STATUS;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  logic [31:0]   addr;
  logic          dp_clr;

  always #5 clk = ~clk;

  instcache_control #(.CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (mem_read),
    .mem_resp       (mem_resp),
    .pmem_resp      (pmem_resp),
    .pmem_read      (pmem_read),
    .HIT            (HIT),
    .way_hit        (way_hit),
    .lru_data       (lru_data),
    .valid_out      (valid_out),
    .LD_LRU_in      (LD_LRU_in),
    .lru_in_value   (lru_in_value),
    .LD_VALID       (LD_VALID),
    .valid_in       (valid_in),
    .LD_TAG         (LD_TAG),
    .W_CACHE_STATUS (W_CACHE_STATUS),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  // Behavioural datapath
  logic [23:0] tagm [8][2];
  logic        vm   [8][2];
  logic        lrum [8];
  logic [2:0]  dset;
  logic        h0, h1;
  logic        lru_ld_r, lru_v_r;
  logic [2:0]  lru_s_r;

  assign dset      = addr[7:5];
  assign h0        = vm[dset][0] && (tagm[dset][0] == addr[31:8]);
  assign h1        = vm[dset][1] && (tagm[dset][1] == addr[31:8]);
  assign HIT       = h0 ^ h1;
  assign way_hit   = h1;
  assign lru_data  = lrum[dset];
  assign valid_out = {vm[dset][1], vm[dset][0]};

  always @(posedge clk) begin
    if (dp_clr) begin
      for (int s = 0; s < 8; s++) begin
        lrum[s] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          tagm[s][w] <= '0;
          vm[s][w]   <= 1'b0;
        end
      end
      lru_ld_r <= 1'b0;
      lru_v_r  <= 1'b0;
      lru_s_r  <= '0;
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (LD_TAG[w])   tagm[dset][w] <= addr[31:8];
        if (LD_VALID[w]) vm[dset][w]   <= valid_in;
      end
      lru_ld_r <= LD_LRU_in;
      lru_v_r  <= lru_in_value;
      lru_s_r  <= dset;
      if (lru_ld_r) lrum[lru_s_r] <= lru_v_r;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int exp_hits = 0;
  int exp_miss = 0;
  int lat_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, " hit_count"},  32'(hit_count),  32'(exp_hits));
    check({tag, " miss_count"}, 32'(miss_count), 32'(exp_miss));
  endtask

  // exp_ld == 0 means a hit is expected; otherwise the way whose tag loads.
  task automatic fetch(input logic [31:0] a, input int n_wait,
                       input logic [1:0] exp_ld, input string tag);
    int   cyc, fcnt;
    bit   done, fill_seen, is_miss;
    logic exp_lv;
    is_miss = (exp_ld != 2'b00);
    lat_q.push_back(is_miss ? n_wait + 3 : 1);
    if (is_miss) exp_miss = (exp_miss < CMAX) ? exp_miss + 1 : CMAX;
    else         exp_hits = (exp_hits < CMAX) ? exp_hits + 1 : CMAX;
    @(negedge clk);
    addr = a;
    mem_read = 1'b1;
    cyc = 0; fcnt = 0; done = 0; fill_seen = 0;
    while (!done && cyc < 40) begin
      cyc++;
      #2;
      if (fill_seen) begin
        check({tag, " fill_wait_quiet"},
              32'({pmem_read, mem_resp, LD_TAG, LD_VALID, W_CACHE_STATUS}), 32'd0);
        fill_seen = 0;
      end
      if (pmem_read) begin
        fcnt++;
        if (fcnt == n_wait) begin
          pmem_resp = 1'b1;
          #1;
          check({tag, " LD_TAG"},   32'(LD_TAG),   32'(exp_ld));
          check({tag, " LD_VALID"}, 32'(LD_VALID), 32'(exp_ld));
          check({tag, " valid_in"}, 32'(valid_in), 32'd1);
          check({tag, " status_fill"}, 32'(W_CACHE_STATUS), 32'b111);
          fill_seen = 1;
        end else begin
          check({tag, " status_fetch"}, 32'(W_CACHE_STATUS), 32'b011);
        end
      end
      if (mem_resp) begin
        check({tag, " latency"}, 32'(cyc), 32'(lat_q.pop_front()));
        exp_lv = ~way_hit;
        check({tag, " LD_LRU_in"}, 32'(LD_LRU_in), 32'd1);
        check({tag, " lru_in_value"}, 32'(lru_in_value), 32'(exp_lv));
        done = 1;
      end
      @(negedge clk);
      pmem_resp = 1'b0;
    end
    mem_read = 1'b0;
    if (!done) begin
      check({tag, " timeout"}, 32'd0, 32'd1);
      if (lat_q.size() > 0) void'(lat_q.pop_front());
    end
    #2;
    check_counts(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_read = 1'b0; pmem_resp = 1'b0; addr = '0; dp_clr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #2;
      check("reset outputs",
            32'({mem_resp, pmem_read, LD_LRU_in, lru_in_value, LD_VALID,
                 valid_in, LD_TAG, W_CACHE_STATUS}), 32'd0);
      check_counts("reset");
    end
    @(negedge clk);
    rst = 1'b0; dp_clr = 1'b0;

    fetch(32'h0000_0040, 4, 2'b01, "cold_A");
    fetch(32'h0000_0044, 0, 2'b00, "rehit_A");
    fetch(32'h0000_0140, 2, 2'b10, "fill_B");
    fetch(32'h0000_0040, 0, 2'b00, "touch_A");
    fetch(32'h0000_0240, 3, 2'b10, "evict_B");
    fetch(32'h0000_0040, 0, 2'b00, "still_A");

    // Reset in the second FETCH cycle, coinciding with pmem_resp.
    @(negedge clk);
    addr = 32'h0000_0400; mem_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    check("rst_mid pmem_read_before", 32'(pmem_read), 32'd1);
    rst = 1'b1; pmem_resp = 1'b1;
    #1;
    check("rst_mid no_loads", 32'({LD_TAG, LD_VALID, valid_in}), 32'd0);
    @(negedge clk);
    rst = 1'b0; pmem_resp = 1'b0; mem_read = 1'b0;
    exp_hits = 0; exp_miss = 0;
    #2;
    check("rst_mid pmem_read_after", 32'(pmem_read), 32'd0);
    check_counts("rst_mid");

    fetch(32'h0000_0400, 3, 2'b01, "miss1");
    fetch(32'h0000_0800, 1, 2'b10, "miss2");
    fetch(32'h0000_0020, 2, 2'b01, "miss3");
    fetch(32'h0000_0060, 5, 2'b01, "miss4_sat");
    fetch(32'h0000_0080, 1, 2'b01, "miss5_sat");
    for (int i = 0; i < 4; i++) fetch(32'h0000_0404, 0, 2'b00, "hit_sat");

    check("scoreboard empty", 32'(lat_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
